// File: rtl/pc_gen_if.sv
// Instruction-fetch request channel between pc_gen (master) and the inst SRAM bridge (slave).
// Carries the req/gnt handshake, the fetch address and the wrong-path kill marker.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req;
    logic [WIDTH-1:0] addr;
    logic             gnt;
    logic             fetch_kill;

    modport master (
        output req,
        output addr,
        output fetch_kill,
        input  gnt
    );

    modport slave (
        input  req,
        input  addr,
        input  fetch_kill,
        output gnt
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirects (exc > eret > branch), stalled-request redirect buffering.
// Optional misaligned-fetch flag enabled by defining PCGEN_ADEL_EN.
module pc_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'hBFC0_0000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'hBFC0_0380,
    parameter int unsigned      INC       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    pc_gen_if.master         bus,
    output logic [WIDTH-1:0] pc,
    output logic             adel
);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    // Numeric order matches redirect priority so buffered vs. new can be compared directly.
    typedef enum logic [1:0] {
        PRI_NONE = 2'd0,
        PRI_BR   = 2'd1,
        PRI_ERET = 2'd2,
        PRI_EXC  = 2'd3
    } pri_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    pri_e             pend_pri_q, pend_pri_d;

    logic             redir_s;
    logic [WIDTH-1:0] redir_tgt_s;
    pri_e             redir_pri_s;
    logic             req_s;
    logic             kill_s;
    logic             take_s;

    // Redirect source selection in priority order.
    always_comb begin
        redir_s     = 1'b0;
        redir_tgt_s = '0;
        redir_pri_s = PRI_NONE;
        if (exc_valid) begin
            redir_s     = 1'b1;
            redir_tgt_s = EXC_VEC;
            redir_pri_s = PRI_EXC;
        end else if (eret_valid) begin
            redir_s     = 1'b1;
            redir_tgt_s = epc;
            redir_pri_s = PRI_ERET;
        end else if (br_valid) begin
            redir_s     = 1'b1;
            redir_tgt_s = br_target;
            redir_pri_s = PRI_BR;
        end else begin
            redir_s     = 1'b0;
            redir_tgt_s = '0;
            redir_pri_s = PRI_NONE;
        end
    end

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_pri_d = pend_pri_q;
        req_s      = 1'b0;
        kill_s     = 1'b0;
        take_s     = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redir_s) begin
                    pc_d = redir_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            RUN: begin
                req_s = en;
                if (en && bus.gnt) begin
                    pc_d = redir_s ? redir_tgt_s : (pc_q + INC_W);
                end else if (en && redir_s) begin
                    // addr must stay put until granted; park the target instead.
                    pend_tgt_d = redir_tgt_s;
                    pend_pri_d = redir_pri_s;
                    state_d    = PEND;
                end else if (!en && redir_s) begin
                    pc_d = redir_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            PEND: begin
                req_s  = 1'b1;
                kill_s = 1'b1;
                take_s = redir_s && (redir_pri_s >= pend_pri_q);
                if (take_s) begin
                    pend_tgt_d = redir_tgt_s;
                    pend_pri_d = redir_pri_s;
                end else begin
                    pend_tgt_d = pend_tgt_q;
                    pend_pri_d = pend_pri_q;
                end
                if (bus.gnt) begin
                    pc_d       = take_s ? redir_tgt_s : pend_tgt_q;
                    pend_tgt_d = '0;
                    pend_pri_d = PRI_NONE;
                    state_d    = RUN;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
            pend_pri_q <= PRI_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_pri_q <= pend_pri_d;
        end
    end

    assign bus.req        = req_s;
    assign bus.addr       = pc_q;
    assign bus.fetch_kill = kill_s;
    assign pc             = pc_q;

`ifdef PCGEN_ADEL_EN
    assign adel = req_s && (pc_q[1:0] != 2'b00);
`else
    assign adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/boot, sequential fetch, stall, redirects, priority, wrap, misalignment.
module tb_pc_gen;
    logic        clk;
    logic        rst;
    logic        en;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        adel;
    logic        exp_adel;

    int errors = 0;
    int checks = 0;

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .exc_valid (exc_valid),
        .eret_valid(eret_valid),
        .epc       (epc),
        .br_valid  (br_valid),
        .br_target (br_target),
        .bus       (bus),
        .pc        (pc),
        .adel      (adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef PCGEN_ADEL_EN
        exp_adel = 1'b1;
`else
        exp_adel = 1'b0;
`endif
        rst = 1'b1; en = 1'b1; exc_valid = 1'b0; eret_valid = 1'b0; epc = 32'h0;
        br_valid = 1'b0; br_target = 32'h0; bus.gnt = 1'b1;
        cyc(); cyc();
        rst = 1'b0; #1;
        chk("boot_req", 32'(bus.req), 32'h0);
        chk("boot_pc", pc, 32'hBFC0_0000);
        chk("boot_kill", 32'(bus.fetch_kill), 32'h0);
        chk("boot_adel", 32'(adel), 32'h0);

        // sequential fetch
        cyc(); #1;
        chk("run0_req", 32'(bus.req), 32'h1);
        chk("run0_addr", bus.addr, 32'hBFC0_0000);
        cyc(); #1; chk("seq1_addr", bus.addr, 32'hBFC0_0004);
        cyc(); #1; chk("seq2_addr", bus.addr, 32'hBFC0_0008);
        cyc(); cyc();

        // stall three cycles at BFC0_0010
        en = 1'b0; #1;
        chk("stall_req", 32'(bus.req), 32'h0);
        chk("stall_pc", pc, 32'hBFC0_0010);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("stall_req", 32'(bus.req), 32'h0);
            chk("stall_pc", pc, 32'hBFC0_0010);
        end
        cyc(); en = 1'b1; #1;
        chk("resume_req", 32'(bus.req), 32'h1);
        chk("resume_addr", bus.addr, 32'hBFC0_0010);
        cyc(); #1; chk("resume_next", bus.addr, 32'hBFC0_0014);

        // redirect while granted
        br_valid = 1'b1; br_target = 32'hBFC0_1000;
        cyc(); br_valid = 1'b0; #1;
        chk("br_gnt_addr", bus.addr, 32'hBFC0_1000);
        chk("br_gnt_kill", 32'(bus.fetch_kill), 32'h0);

        // redirect during ungranted request; en ignored while pending
        bus.gnt = 1'b0; #1;
        chk("ung0_addr", bus.addr, 32'hBFC0_1000);
        chk("ung0_kill", 32'(bus.fetch_kill), 32'h0);
        cyc();
        br_valid = 1'b1; br_target = 32'h8000_0040; #1;
        chk("ung1_addr", bus.addr, 32'hBFC0_1000);
        cyc(); br_valid = 1'b0; en = 1'b0; #1;
        chk("ung2_addr", bus.addr, 32'hBFC0_1000);
        chk("ung2_kill", 32'(bus.fetch_kill), 32'h1);
        chk("pend_en_ign", 32'(bus.req), 32'h1);
        cyc(); en = 1'b1; #1;
        chk("ung3_kill", 32'(bus.fetch_kill), 32'h1);
        bus.gnt = 1'b1;
        cyc(); #1;
        chk("ung_tgt_addr", bus.addr, 32'h8000_0040);
        chk("ung_tgt_kill", 32'(bus.fetch_kill), 32'h0);

        // same-cycle priority
        exc_valid = 1'b1; eret_valid = 1'b1; epc = 32'h8000_0100;
        br_valid = 1'b1; br_target = 32'h8000_0200;
        cyc(); exc_valid = 1'b0; eret_valid = 1'b0; br_valid = 1'b0; #1;
        chk("prio_addr", bus.addr, 32'hBFC0_0380);

        // buffered exc not displaced by later branch
        bus.gnt = 1'b0; exc_valid = 1'b1;
        cyc(); exc_valid = 1'b0; br_valid = 1'b1; br_target = 32'h8000_0300; #1;
        chk("pexc_kill", 32'(bus.fetch_kill), 32'h1);
        cyc(); br_valid = 1'b0; bus.gnt = 1'b1;
        cyc(); #1;
        chk("exc_kept", bus.addr, 32'hBFC0_0380);

        // buffered branch displaced by later exc
        bus.gnt = 1'b0; br_valid = 1'b1; br_target = 32'h8000_0400;
        cyc(); br_valid = 1'b0; exc_valid = 1'b1;
        cyc(); exc_valid = 1'b0; bus.gnt = 1'b1;
        cyc(); #1;
        chk("exc_over_br", bus.addr, 32'hBFC0_0380);

        // same-cycle eret at grant overrides buffered branch
        bus.gnt = 1'b0; br_valid = 1'b1; br_target = 32'h8000_0500;
        cyc(); br_valid = 1'b0; bus.gnt = 1'b1; eret_valid = 1'b1; epc = 32'h8000_0600;
        cyc(); eret_valid = 1'b0; #1;
        chk("eret_at_gnt", bus.addr, 32'h8000_0600);

        // wrap-around
        br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
        cyc(); br_valid = 1'b0; #1;
        chk("wrap_pre", bus.addr, 32'hFFFF_FFFC);
        cyc(); #1;
        chk("wrap_post", bus.addr, 32'h0000_0000);

        // idle redirect loads pc directly
        en = 1'b0; br_valid = 1'b1; br_target = 32'h8000_0700;
        cyc(); br_valid = 1'b0; #1;
        chk("idle_br_pc", pc, 32'h8000_0700);
        chk("idle_br_req", 32'(bus.req), 32'h0);
        en = 1'b1; #1;
        chk("idle_br_addr", bus.addr, 32'h8000_0700);

        // misaligned target
        br_valid = 1'b1; br_target = 32'hBFC0_0002;
        cyc(); br_valid = 1'b0; #1;
        chk("mis_addr", bus.addr, 32'hBFC0_0002);
        chk("mis_adel", 32'(adel), 32'(exp_adel));

        // reset while pending, then redirect during BOOT
        bus.gnt = 1'b0; br_valid = 1'b1; br_target = 32'h8000_0800;
        cyc(); br_valid = 1'b0; #1;
        chk("prerst_kill", 32'(bus.fetch_kill), 32'h1);
        rst = 1'b1; bus.gnt = 1'b1;
        cyc(); rst = 1'b0; #1;
        chk("rst_pc", pc, 32'hBFC0_0000);
        chk("rst_req", 32'(bus.req), 32'h0);
        chk("rst_kill", 32'(bus.fetch_kill), 32'h0);
        br_valid = 1'b1; br_target = 32'h8000_0900;
        cyc(); br_valid = 1'b0; bus.gnt = 1'b0; #1;
        chk("boot_br_addr", bus.addr, 32'h8000_0900);
        chk("boot_br_kill", 32'(bus.fetch_kill), 32'h0);
        bus.gnt = 1'b1;
        cyc(); #1;
        chk("post_rst_seq", bus.addr, 32'h8000_0904);
        chk("post_rst_kill", 32'(bus.fetch_kill), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
